// File: rtl/traffic_phase_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// traffic_phase_ctrl_if : control/config inputs and light/display outputs
// Revision: 1.0
// ----------------------------------------------------------------------------
interface traffic_phase_ctrl_if;
  logic       en;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [3:0] cfg_val;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [2:0] phase;
  logic [3:0] sec_left;
  logic       tick;
  logic       ped_wait;

  modport master (
    output en, cfg_we, cfg_sel, cfg_val, ped_req,
    input  ns_light, ew_light, phase, sec_left, tick, ped_wait
  );

  modport slave (
    input  en, cfg_we, cfg_sel, cfg_val, ped_req,
    output ns_light, ew_light, phase, sec_left, tick, ped_wait
  );
endinterface
`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// traffic_phase_ctrl : two-road light sequencer with per-second countdown,
//                      programmable phase durations and pedestrian shortcut
// Revision: 1.0
// ----------------------------------------------------------------------------
module traffic_phase_ctrl #(
  parameter int TICK_DIV = 25_000_000,
  parameter int DEF_G_NS = 8,
  parameter int DEF_G_EW = 6,
  parameter int DEF_Y    = 2,
  parameter int DEF_R    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  traffic_phase_ctrl_if.slave  bus
);

  localparam int             CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  PRES_MAX = CW'(TICK_DIV - 1);
  localparam logic [3:0]     G_NS_RST = 4'(DEF_G_NS);
  localparam logic [3:0]     G_EW_RST = 4'(DEF_G_EW);
  localparam logic [3:0]     Y_RST    = 4'(DEF_Y);
  localparam logic [3:0]     R_RST    = 4'(DEF_R);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    RED_A = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    RED_B = 3'd5
  } phase_t;

  phase_t          state;
  logic [3:0]      sec_cnt;
  logic [CW-1:0]   pres_cnt;
  logic [3:0]      g_ns_dur;
  logic [3:0]      g_ew_dur;
  logic [3:0]      y_dur;
  logic [3:0]      r_dur;
  logic            ped_pending;

  logic            tick_now;
  logic            state_legal;
  logic            phase_end;
  logic            enter_ew;
  phase_t          next_state;
  logic [3:0]      raw_dur;
  logic [3:0]      load_val;
  logic [3:0]      r_load;

  assign tick_now    = rst & bus.en & (pres_cnt == PRES_MAX);
  assign state_legal = (state <= RED_B);
  // sec_cnt==0 cannot occur in normal operation; treating it as "last second" keeps it out of the wrap
  assign phase_end   = (sec_cnt <= 4'd1);
  assign enter_ew    = tick_now & state_legal & phase_end & (state == RED_A);
  assign r_load      = (r_dur == 4'd0) ? 4'd1 : r_dur;

  always_comb begin
    next_state = NS_G;
    case (state)
      NS_G:    next_state = NS_Y;
      NS_Y:    next_state = RED_A;
      RED_A:   next_state = EW_G;
      EW_G:    next_state = EW_Y;
      EW_Y:    next_state = RED_B;
      default: next_state = NS_G;
    endcase
  end

  // The load uses the registers as they stand before this edge, so a same-edge write is not seen
  always_comb begin
    raw_dur = r_dur;
    case (next_state)
      NS_G:       raw_dur = g_ns_dur;
      EW_G:       raw_dur = g_ew_dur;
      NS_Y, EW_Y: raw_dur = y_dur;
      default:    raw_dur = r_dur;
    endcase
    load_val = (raw_dur == 4'd0) ? 4'd1 : raw_dur;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= RED_B;
      sec_cnt     <= R_RST;
      pres_cnt    <= '0;
      g_ns_dur    <= G_NS_RST;
      g_ew_dur    <= G_EW_RST;
      y_dur       <= Y_RST;
      r_dur       <= R_RST;
      ped_pending <= 1'b0;
    end else begin
      if (bus.en) begin
        pres_cnt <= (pres_cnt == PRES_MAX) ? '0 : pres_cnt + 1'b1;
      end

      if (bus.cfg_we) begin
        case (bus.cfg_sel)
          2'd0:    g_ns_dur <= bus.cfg_val;
          2'd1:    g_ew_dur <= bus.cfg_val;
          2'd2:    y_dur    <= bus.cfg_val;
          default: r_dur    <= bus.cfg_val;
        endcase
      end

      if (!state_legal) begin
        state   <= RED_B;
        sec_cnt <= r_load;
      end else if (tick_now) begin
        if (phase_end) begin
          state   <= next_state;
          sec_cnt <= load_val;
        end else if ((state == NS_G) && ped_pending && (sec_cnt > 4'd2)) begin
          sec_cnt <= 4'd2;
        end else begin
          sec_cnt <= sec_cnt - 4'd1;
        end
      end

      if (bus.ped_req) begin
        ped_pending <= 1'b1;
      end else if (enter_ew) begin
        ped_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.ns_light = 3'b100;
    bus.ew_light = 3'b100;
    case (state)
      NS_G:    bus.ns_light = 3'b001;
      NS_Y:    bus.ns_light = 3'b010;
      EW_G:    bus.ew_light = 3'b001;
      EW_Y:    bus.ew_light = 3'b010;
      default: ;
    endcase
  end

  assign bus.phase    = state;
  assign bus.sec_left = sec_cnt;
  assign bus.tick     = tick_now;
  assign bus.ped_wait = ped_pending;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_traffic_phase_ctrl : directed vector table plus randomized run against a
//                         phase-list reference model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_traffic_phase_ctrl;
  localparam int TICK_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  traffic_phase_ctrl_if tif();

  traffic_phase_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (tif.slave)
  );

  always #5 clk = ~clk;

  // Reference model: phase number 0..5 in the listed order, durations by register index
  int m_phase, m_sec, m_pres;
  int m_dur[4];
  bit m_ped;

  function automatic int reg_of(input int p);
    if (p == 0) return 0;
    if (p == 3) return 1;
    if (p == 1 || p == 4) return 2;
    return 3;
  endfunction

  function automatic logic [2:0] light_of(input int p, input bit ns_road);
    int g, y;
    g = ns_road ? 0 : 3;
    y = ns_road ? 1 : 4;
    if (p == g) return 3'b001;
    if (p == y) return 3'b010;
    return 3'b100;
  endfunction

  task automatic model_step(input bit r, e, we, input int sel, val, input bit ped);
    bit t, ew_entry;
    int d;
    if (!r) begin
      m_phase = 5; m_sec = 1; m_pres = 0; m_ped = 0;
      m_dur[0] = 8; m_dur[1] = 6; m_dur[2] = 2; m_dur[3] = 1;
      return;
    end
    t = e && (m_pres == TICK_DIV - 1);
    if (e) m_pres = (m_pres + 1) % TICK_DIV;
    ew_entry = 0;
    if (t) begin
      if (m_sec == 1) begin
        m_phase = (m_phase + 1) % 6;
        d = m_dur[reg_of(m_phase)];
        m_sec = (d == 0) ? 1 : d;
        ew_entry = (m_phase == 3);
      end else if (m_phase == 0 && m_ped && m_sec > 2) begin
        m_sec = 2;
      end else begin
        m_sec = m_sec - 1;
      end
    end
    if (ew_entry) m_ped = 0;
    if (ped) m_ped = 1;
    if (we) m_dur[sel] = val;
  endtask

  task automatic check_model(input bit r, e);
    bit exp_tick;
    exp_tick = r && e && (m_pres == TICK_DIV - 1);
    checks++;
    if (int'(tif.phase) != m_phase || int'(tif.sec_left) != m_sec ||
        tif.ns_light != light_of(m_phase, 1'b1) || tif.ew_light != light_of(m_phase, 1'b0) ||
        tif.tick != exp_tick || tif.ped_wait != m_ped) begin
      errors++;
      $display("FAIL model_cycle t=%0t got ph=%0d sec=%0d ns=%b ew=%b tick=%b pw=%b exp ph=%0d sec=%0d ns=%b ew=%b tick=%b pw=%b",
               $time, tif.phase, tif.sec_left, tif.ns_light, tif.ew_light, tif.tick, tif.ped_wait,
               m_phase, m_sec, light_of(m_phase, 1'b1), light_of(m_phase, 1'b0), exp_tick, m_ped);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge
  task automatic cycle(input bit r, e, we, input logic [1:0] sel, input logic [3:0] val, input bit ped);
    rst         = r;
    tif.en      = e;
    tif.cfg_we  = we;
    tif.cfg_sel = sel;
    tif.cfg_val = val;
    tif.ped_req = ped;
    @(posedge clk);
    model_step(r, e, we, int'(sel), int'(val), ped);
    @(negedge clk);
    check_model(r, e);
  endtask

  typedef struct {
    bit         r, e, we;
    logic [1:0] sel;
    logic [3:0] val;
    bit         ped;
    int         n;
    int         ph, sec;
    bit         pw;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit r, e, we, input int sel, val, input bit ped,
                              input int n, ph, sec, input bit pw);
    vec_t v;
    v.r = r; v.e = e; v.we = we; v.sel = 2'(sel); v.val = 4'(val); v.ped = ped;
    v.n = n; v.ph = ph; v.sec = sec; v.pw = pw;
    tbl.push_back(v);
  endfunction

  initial begin
    tif.en = 1'b0; tif.cfg_we = 1'b0; tif.cfg_sel = 2'd0; tif.cfg_val = 4'd0; tif.ped_req = 1'b0;
    // reset, first tick, one free-running cycle of phases
    add(0,1,0,0,0,0, 2, 5,1,0);
    add(1,1,0,0,0,0, 3, 5,1,0);
    add(1,1,0,0,0,0, 1, 0,8,0);
    add(1,1,0,0,0,0,32, 1,2,0);
    add(1,1,0,0,0,0, 8, 2,1,0);
    add(1,1,0,0,0,0, 4, 3,6,0);
    add(1,1,0,0,0,0,24, 4,2,0);
    add(1,1,0,0,0,0, 8, 5,1,0);
    add(1,1,0,0,0,0, 4, 0,8,0);
    // pedestrian shortcut from sec_left=6
    add(1,1,0,0,0,0, 8, 0,6,0);
    add(1,1,0,0,0,1, 1, 0,6,1);
    add(1,1,0,0,0,0, 3, 0,2,1);
    add(1,1,0,0,0,0, 4, 0,1,1);
    add(1,1,0,0,0,0, 4, 1,2,1);
    add(1,1,0,0,0,0, 8, 2,1,1);
    add(1,1,0,0,0,0, 4, 3,6,0);
    add(1,1,0,0,0,0,20, 3,1,0);
    add(1,1,0,0,0,0, 4, 4,2,0);
    add(1,1,0,0,0,0, 8, 5,1,0);
    add(1,1,0,0,0,0, 4, 0,8,0);
    // G_EW=3 and Y=0 written during NS_G
    add(1,1,1,1,3,0, 1, 0,8,0);
    add(1,1,1,2,0,0, 1, 0,8,0);
    add(1,1,0,0,0,0, 2, 0,7,0);
    add(1,1,0,0,0,0,28, 1,1,0);
    add(1,1,0,0,0,0, 4, 2,1,0);
    add(1,1,0,0,0,0, 4, 3,3,0);
    add(1,1,0,0,0,0, 8, 3,1,0);
    add(1,1,0,0,0,0, 4, 4,1,0);
    add(1,1,0,0,0,0, 4, 5,1,0);
    add(1,1,0,0,0,0, 4, 0,8,0);
    // enable dropped mid-phase
    add(1,1,0,0,0,0, 5, 0,7,0);
    add(1,0,0,0,0,0,10, 0,7,0);
    add(1,1,0,0,0,0, 2, 0,7,0);
    add(1,1,0,0,0,0, 1, 0,6,0);
    // reach EW_Y with a pending request, then reset mid-run
    add(1,1,0,0,0,1, 1, 0,6,1);
    add(1,1,0,0,0,0, 3, 0,2,1);
    add(1,1,0,0,0,0, 4, 0,1,1);
    add(1,1,0,0,0,0, 4, 1,1,1);
    add(1,1,0,0,0,0, 4, 2,1,1);
    add(1,1,0,0,0,0, 4, 3,3,0);
    add(1,1,0,0,0,1, 1, 3,3,1);
    add(1,1,0,0,0,0, 3, 3,2,1);
    add(1,1,0,0,0,0, 8, 4,1,1);
    add(0,1,0,0,0,0, 1, 5,1,0);
    add(1,1,0,0,0,0, 4, 0,8,0);
    add(1,1,0,0,0,0,32, 1,2,0);
    add(1,1,0,0,0,0, 8, 2,1,0);
    add(1,1,0,0,0,0, 4, 3,6,0);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++)
        cycle(tbl[i].r, tbl[i].e, tbl[i].we, tbl[i].sel, tbl[i].val, tbl[i].ped);
      checks++;
      if (int'(tif.phase) != tbl[i].ph || int'(tif.sec_left) != tbl[i].sec || tif.ped_wait != tbl[i].pw) begin
        errors++;
        $display("FAIL vector_%0d got ph=%0d sec=%0d pw=%b exp ph=%0d sec=%0d pw=%b",
                 i, tif.phase, tif.sec_left, tif.ped_wait, tbl[i].ph, tbl[i].sec, tbl[i].pw);
      end
    end

    for (int k = 0; k < 3000; k++) begin
      cycle($urandom_range(0, 399) != 0,
            $urandom_range(0, 9) != 0,
            $urandom_range(0, 19) == 0,
            2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)),
            $urandom_range(0, 29) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
- Sequencer for the two-road traffic light: steps NS/EW through green, yellow and all-red phases, each lasting a programmable number of seconds.
- Owns the per-second countdown, the phase duration registers and a pedestrian-request shortcut.
- Feeds the light LEDs and the seven-segment path with the current phase and the seconds remaining.
- Sits between the debounced buttons/switch configuration and the display logic.

Parameters:
- TICK_DIV, 25_000_000, clk cycles per one-second tick (25 MHz clk); bench uses 4.
- DEF_G_NS, 8, reset value of the NS green duration (s).
- DEF_G_EW, 6, reset value of the EW green duration (s).
- DEF_Y, 2, reset value of the yellow duration (s), shared by both roads.
- DEF_R, 1, reset value of the all-red duration (s), shared by both all-red phases.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- en  in  1  1 = run; 0 = freeze prescaler, phase and countdown.
- cfg_we  in  1  1-cycle write strobe for a duration register.
- cfg_sel  in  2  register select: 0 G_NS, 1 G_EW, 2 Y, 3 R.
- cfg_val  in  4  duration value (s).
- ped_req  in  1  debounced 1-cycle pedestrian request pulse.
- ns_light  out  3  {red,yellow,green} for NS, one-hot.
- ew_light  out  3  {red,yellow,green} for EW, one-hot.
- phase  out  3  current phase code.
- sec_left  out  4  seconds remaining in the current phase, 1..15.
- tick  out  1  1-cycle pulse on each one-second boundary.
- ped_wait  out  1  pedestrian request pending.

Behaviour:
- Phase codes: 0 NS_G, 1 NS_Y, 2 RED_A, 3 EW_G, 4 EW_Y, 5 RED_B. Codes 6 and 7 are illegal and go to RED_B with sec_left = R on the next cycle.
- Phase order: NS_G -> NS_Y -> RED_A -> EW_G -> EW_Y -> RED_B -> NS_G.
- Light mapping:
  - NS_G: ns=001, ew=100.
  - NS_Y: ns=010, ew=100.
  - EW_G: ns=100, ew=001.
  - EW_Y: ns=100, ew=010.
  - RED_A, RED_B: both 100.
- Reset (rst=0 at an edge):
  - phase=RED_B, sec_left=DEF_R, prescaler=0, tick=0, ped_wait=0.
  - Duration registers load their DEF_* values.
  - Lights are driven combinationally from phase, so both read 100 during reset.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while en=1; holds its value while en=0.
  - tick=1 in the cycle the count equals TICK_DIV-1; the count wraps to 0 on that edge.
- On tick with sec_left>1: sec_left decrements by 1, phase unchanged.
- On tick with sec_left==1: phase advances and sec_left loads the next phase's duration.
  - A duration register holding 0 loads as 1.
  - There is no 0-second phase, and sec_left never reads 0.
- Configuration:
  - cfg_we writes cfg_val into the selected register on that edge.
  - A phase uses the register value as it stood before the load edge. A write on the same edge as a load is not seen by that load.
  - Writes never alter the running sec_left.
  - Writes are accepted regardless of en.
- Pedestrian request:
  - ped_req=1 sets ped_pending (= ped_wait) on the next edge, in any phase.
  - In NS_G with ped_pending=1, a tick with sec_left>2 sets sec_left=2 instead of decrementing.
  - A tick with sec_left<=2 behaves normally.
  - ped_pending clears on the edge that enters EW_G.
  - A ped_req on that same edge keeps it set (set wins).
  - A request raised in any other phase waits for the next NS_G.
- en=0: tick=0, state held, cfg and ped latching still active.
- Output latency: outputs change on the tick edge, so new values are visible the cycle after tick=1.
- Mid-operation reset: the next edge forces the reset state regardless of en or tick.

Test Plan:
1. TICK_DIV=4, rst low 2 cycles then high, en=1 -> RED_B/sec_left=1. First tick at cycle 4 after release; then NS_G, sec_left=8, ns=001, ew=100.
2. Free run 20 ticks (80 cycles) -> phase sequence 5,0(8s),1(2s),2(1s),3(6s),4(2s),5(1s), then back to NS_G. Lights one-hot and correct in every phase; sec_left never 0.
3. During NS_G with sec_left=6, pulse ped_req -> ped_wait=1. Next tick sec_left=2, then 1, then NS_Y. ped_wait clears on entering EW_G.
4. In NS_G, write cfg_sel=1 cfg_val=3 -> current sec_left unaffected; the following EW_G lasts 3 ticks. Write cfg_sel=2 cfg_val=0 -> yellow phases last 1 tick.
5. Drop en for 10 cycles mid-phase -> tick stays 0, phase/sec_left/prescaler frozen. Resume continues with no tick lost or added.
6. Assert rst=0 for 1 cycle during EW_Y with ped_wait=1 and modified cfg -> RED_B, sec_left=1, ped_wait=0, durations back to defaults.
